// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, keycode
// layout, column reset pattern and small row/column decoding helpers.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam int KEY_VALID_BIT = 4;
  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Index of the low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to all-ones,
// used to bring the pulled-up keypad row lines into the clk5 domain.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces
// single-key presses and releases, and emits one keycode/newkey per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] keycode,
  output logic       newkey,
  output logic       keyheld
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DC_LAST   = 4'(DEBOUNCE_CNT);

  logic [3:0]    rs;
  logic [SW-1:0] slot;
  logic          sample;

  state_e     state, state_n;
  logic [3:0] col_n;
  logic [3:0] dcnt, dcnt_n;
  logic [3:0] cand_rs, cand_rs_n;
  logic [1:0] cand_row, cand_row_n;
  logic [1:0] cand_col, cand_col_n;
  logic       held_clr;
  logic [4:0] emit_code;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk5),
    .rst_n (reset),
    .d     (row),
    .q     (rs)
  );

  assign sample = (slot == SLOT_LAST);
  assign newkey = (state == EMIT);

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      slot <= '0;
    end else if (sample) begin
      slot <= '0;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    col_n      = col;
    dcnt_n     = dcnt;
    cand_rs_n  = cand_rs;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    held_clr   = 1'b0;
    unique case (state)
      SCAN: begin
        if (sample) begin
          if (one_low(rs)) begin
            cand_rs_n  = rs;
            cand_row_n = low_index(rs);
            cand_col_n = low_index(col);
            if (DC_LAST <= 4'd1) begin
              dcnt_n  = '0;
              state_n = EMIT;
            end else begin
              dcnt_n  = 4'd1;
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = {col[2:0], col[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (rs == cand_rs) begin
            if (dcnt + 4'd1 >= DC_LAST) begin
              dcnt_n  = '0;
              state_n = EMIT;
            end else begin
              dcnt_n = dcnt + 4'd1;
            end
          end else begin
            dcnt_n  = '0;
            state_n = SCAN;
            col_n   = {col[2:0], col[3]};
          end
        end
      end
      EMIT: begin
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (sample) begin
          if (rs == 4'b1111) begin
            if (dcnt + 4'd1 >= DC_LAST) begin
              dcnt_n   = '0;
              held_clr = 1'b1;
              state_n  = SCAN;
              col_n    = {col[2:0], col[3]};
            end else begin
              dcnt_n = dcnt + 4'd1;
            end
          end else begin
            dcnt_n = '0;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_comb begin
    emit_code                = {1'b0, cand_row_n, cand_col_n};
    emit_code[KEY_VALID_BIT] = 1'b1;
  end

  // keycode/keyheld load on entry to EMIT so they are already valid while newkey is high.
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      col      <= COL_RESET;
      dcnt     <= '0;
      cand_rs  <= '1;
      cand_row <= '0;
      cand_col <= '0;
      keycode  <= '0;
      keyheld  <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      dcnt     <= dcnt_n;
      cand_rs  <= cand_rs_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
      if (state_n == EMIT) begin
        keycode <= emit_code;
        keyheld <= 1'b1;
      end else if (held_clr) begin
        keyheld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// rows from the column strobe; expected keycodes come from row*4+col arithmetic.
module tb_keypad_scanner;

  logic       clk5 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] keycode;
  logic       newkey;
  logic       keyheld;

  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_count = 0;
  logic [4:0] ev_q[$];
  logic prev_nk = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk5    (clk5),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .keycode (keycode),
    .newkey  (newkey),
    .keyheld (keyheld)
  );

  always #5 clk5 = ~clk5;

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk5) begin
    if (!reset) begin
      prev_nk = 1'b0;
    end else begin
      if (newkey) begin
        ev_count++;
        ev_q.push_back(keycode);
        n_checks++;
        if (prev_nk) begin
          n_fail++;
          $display("FAIL newkey_width: newkey high on consecutive cycles at %0t, required single-cycle", $time);
        end
      end
      prev_nk = newkey;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] code_of(input int r, input int c);
    return 5'(16 + r*4 + c);
  endfunction

  task automatic wait_event(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk5);
      if (ev_count > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk5);
      if (!keyheld) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: keyheld=%b after 60 cycles, required 0", name, keyheld);
    end
    repeat (4) @(negedge clk5);
  endtask

  task automatic press_and_expect(input string name, input int r, input int c);
    int start;
    bit ok;
    start = ev_count;
    keys[r*4+c] = 1'b1;
    wait_event(start, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_event: no newkey within 300 cycles, required one", name);
    end else begin
      n_checks++;
      if (ev_q[ev_q.size()-1] !== code_of(r, c)) begin
        n_fail++;
        $display("FAIL %s_keycode: got %b, required %b", name, ev_q[ev_q.size()-1], code_of(r, c));
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk5);
    n_checks++;
    if ({col, keycode, newkey, keyheld} !== {4'b1110, 5'b00000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: col=%b keycode=%b newkey=%b keyheld=%b, required 1110 00000 0 0",
               col, keycode, newkey, keyheld);
    end
    reset = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      logic [3:0] exp_col;
      @(negedge clk5);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      n_checks++;
      if (col !== exp_col || newkey !== 1'b0 || keycode !== 5'b00000) begin
        n_fail++;
        $display("FAIL idle_scan: n=%0d col=%b newkey=%b keycode=%b, required col=%b newkey=0 keycode=00000",
                 n, col, newkey, keycode, exp_col);
      end
    end
  endtask

  task automatic test_steady_press;
    int start;
    start = ev_count;
    press_and_expect("steady", 0, 2);
    n_checks++;
    if (keyheld !== 1'b1) begin
      n_fail++;
      $display("FAIL steady_held: keyheld=%b, required 1", keyheld);
    end
    repeat (150) @(negedge clk5);
    n_checks++;
    if (ev_count - start !== 1 || keyheld !== 1'b1) begin
      n_fail++;
      $display("FAIL steady_single: events=%0d keyheld=%b, required 1 event keyheld=1", ev_count - start, keyheld);
    end
    keys = '0;
    repeat (8) @(negedge clk5);
    n_checks++;
    if (keyheld !== 1'b1) begin
      n_fail++;
      $display("FAIL steady_early_release: keyheld=%b 8 cycles after release, required 1", keyheld);
    end
    wait_held_low("steady");
  endtask

  task automatic test_bounce;
    int start;
    int idx;
    bit ok;
    idx = 1*4 + 2;
    start = ev_count;
    // Align to column 2 so the bounce is actually seen by the scanner.
    for (int i = 0; i < 40 && col !== 4'b1011; i++) @(negedge clk5);
    keys[idx] = 1'b1;
    repeat (3) @(negedge clk5);
    keys[idx] = 1'b0;
    repeat (5) @(negedge clk5);
    keys[idx] = 1'b1;
    wait_event(start, ok);
    repeat (100) @(negedge clk5);
    n_checks++;
    if (!ok || ev_count - start !== 1) begin
      n_fail++;
      $display("FAIL bounce_count: events=%0d, required 1", ev_count - start);
    end
    n_checks++;
    if (keycode !== code_of(1, 2)) begin
      n_fail++;
      $display("FAIL bounce_keycode: got %b, required %b", keycode, code_of(1, 2));
    end
    keys = '0;
    wait_held_low("bounce");
  endtask

  task automatic test_chord;
    int start;
    int changes;
    logic [4:0] kc_before;
    logic [3:0] prev_col;
    start = ev_count;
    kc_before = keycode;
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    repeat (20) @(negedge clk5);
    changes = 0;
    prev_col = col;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk5);
      if (col !== prev_col) changes++;
      prev_col = col;
    end
    repeat (100) @(negedge clk5);
    n_checks++;
    if (ev_count - start !== 0 || keycode !== kc_before) begin
      n_fail++;
      $display("FAIL chord_reject: events=%0d keycode=%b, required 0 events keycode=%b",
               ev_count - start, keycode, kc_before);
    end
    n_checks++;
    if (changes !== 16) begin
      n_fail++;
      $display("FAIL chord_rotate: %0d col changes in 64 cycles, required 16", changes);
    end
    keys = '0;
    repeat (20) @(negedge clk5);
  endtask

  task automatic test_reset_mid_hold;
    int start;
    bit ok;
    press_and_expect("midhold_first", 0, 2);
    repeat (20) @(negedge clk5);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({col, keycode, newkey, keyheld} !== {4'b1110, 5'b00000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midhold_reset: col=%b keycode=%b newkey=%b keyheld=%b, required 1110 00000 0 0",
               col, keycode, newkey, keyheld);
    end
    start = ev_count;
    repeat (3) @(negedge clk5);
    reset = 1'b1;
    wait_event(start, ok);
    repeat (60) @(negedge clk5);
    n_checks++;
    if (!ok || ev_count - start !== 1 || keycode !== code_of(0, 2)) begin
      n_fail++;
      $display("FAIL midhold_reevent: events=%0d keycode=%b, required 1 event keycode=%b",
               ev_count - start, keycode, code_of(0, 2));
    end
    keys = '0;
    wait_held_low("midhold");
  endtask

  task automatic test_back_to_back;
    int start;
    start = ev_count;
    press_and_expect("b2b_first", 0, 2);
    repeat (30) @(negedge clk5);
    keys = '0;
    wait_held_low("b2b_first");
    press_and_expect("b2b_second", 1, 2);
    repeat (30) @(negedge clk5);
    keys = '0;
    wait_held_low("b2b_second");
    n_checks++;
    if (ev_count - start !== 2 || ev_q[ev_q.size()-2] !== code_of(0, 2) || ev_q[ev_q.size()-1] !== code_of(1, 2)) begin
      n_fail++;
      $display("FAIL b2b_sequence: events=%0d, required 2 events 10010 then 10110", ev_count - start);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      int r;
      int c;
      int start;
      r = int'($urandom_range(3));
      c = int'($urandom_range(3));
      start = ev_count;
      press_and_expect("random", r, c);
      repeat ($urandom_range(60, 10)) @(negedge clk5);
      n_checks++;
      if (ev_count - start !== 1 || keyheld !== 1'b1) begin
        n_fail++;
        $display("FAIL random_hold: key r%0d c%0d events=%0d keyheld=%b, required 1 event keyheld=1",
                 r, c, ev_count - start, keyheld);
      end
      keys = '0;
      wait_held_low("random");
    end
  endtask

  initial begin
    test_reset;
    test_steady_press;
    test_bounce;
    test_chord;
    test_reset_mid_hold;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
